// File: rtl/lut_u_arbiter_pkg.sv
// Shared encoder constants and helpers for the u-value LUT and its arbiter.
package lut_u_arbiter_pkg;

  localparam int unsigned LUT_ADDR_W = 8;
  localparam int unsigned LUT_DATA_W = 16;
  localparam int unsigned NSYM_W     = 4;

  typedef struct packed {
    logic [NSYM_W-1:0] nsyms;
    logic [NSYM_W-1:0] symbol;
  } lut_req_t;

  function automatic logic [LUT_ADDR_W-1:0] pack_addr(input logic [NSYM_W-1:0] nsyms,
                                                      input logic [NSYM_W-1:0] symbol);
    return {nsyms, symbol};
  endfunction

  // Requester ID width: ceil(log2(n)), never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lut_u_arbiter_if.sv
// Requester, LUT and result signals of the shared u-LUT arbiter.
interface lut_u_arbiter_if
  import lut_u_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_W       = 1,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*NSYM_W-1:0] req_nsyms;
  logic [NUM_REQ*NSYM_W-1:0] req_symbol;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_WIDTH-1:0]     lut_addr;
  logic [DATA_WIDTH-1:0]     lut_q;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_u;
  logic [ID_W-1:0]           out_id;
  logic                      out_err;

  modport slave (
    input  req_valid, req_nsyms, req_symbol, lut_q, out_ready,
    output req_ready, lut_addr, out_valid, out_u, out_id, out_err
  );

  modport master (
    output req_valid, req_nsyms, req_symbol, lut_q, out_ready,
    input  req_ready, lut_addr, out_valid, out_u, out_id, out_err
  );

endinterface

// File: rtl/lut_u_arbiter_rr_arbiter.sv
// Round-robin arbiter; the pointer moves only when the grant is actually taken.
module lut_u_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    win_c,
  output logic               any_c
);

  logic [ID_W-1:0] last_gnt;

  // Search last_gnt+1, last_gnt+2, ... wrapping at NUM_REQ.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idx_w;
    idx   = 0;
    idx_w = '0;
    win_c = '0;
    any_c = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_gnt) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (!any_c && req[idx_w]) begin
        any_c = 1'b1;
        win_c = idx_w;
      end
    end
    gnt_c = any_c ? (NUM_REQ'(1) << win_c) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= ID_W'(NUM_REQ - 1);
    end else if (en && any_c) begin
      last_gnt <= win_c;
    end
  end

endmodule

// File: rtl/lut_u_arbiter.sv
// Shares one combinational u-value LUT between encoder lanes through a
// two-stage pipeline: S1 holds the LUT address, S2 holds the returned result.
module lut_u_arbiter
  import lut_u_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_W       = id_width(NUM_REQ),
  parameter int unsigned DATA_WIDTH = LUT_DATA_W,
  parameter int unsigned ADDR_WIDTH = LUT_ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  lut_u_arbiter_if.slave bus
);

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [ID_W-1:0]       s1_id;
  logic                  s1_err;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_u_q;
  logic [ID_W-1:0]       out_id_q;
  logic                  out_err_q;

  logic                  s2_adv_c;
  logic                  s1_free_c;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [ID_W-1:0]       win_c;
  logic                  any_c;
  lut_req_t              sel_c;

  lut_u_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req_valid),
    .en    (s1_free_c),
    .gnt_c (gnt_c),
    .win_c (win_c),
    .any_c (any_c)
  );

  assign s2_adv_c  = s1_valid & (~out_valid_q | bus.out_ready);
  assign s1_free_c = ~s1_valid | s2_adv_c;

  // Winning lane's fields.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_c == ID_W'(i)) begin
        sel_c.nsyms  = bus.req_nsyms[NSYM_W*i +: NSYM_W];
        sel_c.symbol = bus.req_symbol[NSYM_W*i +: NSYM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s1_id       <= '0;
      s1_err      <= 1'b0;
      out_valid_q <= 1'b0;
      out_u_q     <= '0;
      out_id_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (s1_free_c) begin
        s1_valid <= any_c;
        if (any_c) begin
          s1_addr <= ADDR_WIDTH'(pack_addr(sel_c.nsyms, sel_c.symbol));
          s1_id   <= win_c;
          s1_err  <= (sel_c.symbol > sel_c.nsyms);
        end
      end
      // lut_q is valid for the address held in S1 during this cycle.
      if (s2_adv_c) begin
        out_valid_q <= 1'b1;
        out_u_q     <= bus.lut_q;
        out_id_q    <= s1_id;
        out_err_q   <= s1_err;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = gnt_c & {NUM_REQ{s1_free_c}};
  assign bus.lut_addr  = s1_addr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_u     = out_u_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_err   = out_err_q;

endmodule
